// File: rtl/barcode_render_pkg.sv
// barcode_render_pkg: shared constants for the barcode pixel stage, the UART
// loader and the pattern ROM wrapper.
// Holds colour constants, ROM/counter widths, sync payload struct and the
// module-bit ordering (module m lives in byte m[6:3], bit m[2:0]).
package barcode_render_pkg;

  localparam int unsigned ROM_AW     = 5;
  localparam int unsigned MOD_IDX_W  = 7;
  localparam int unsigned PIX_CNT_W  = 4;
  localparam int unsigned BYTE_IDX_W = 4;
  localparam int unsigned BIT_SEL_W  = 3;
  localparam int unsigned RGB_W      = 24;

  localparam logic [RGB_W-1:0] RGB_BLACK  = 24'h000000;
  localparam logic [RGB_W-1:0] RGB_WHITE  = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] RGB_GREY   = 24'h404040;
  localparam logic [RGB_W-1:0] RGB_BORDER = 24'hFF0000;
  localparam logic [RGB_W-1:0] RGB_OFF    = 24'h000000;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  // Byte of the pattern ROM that holds module m.
  function automatic logic [BYTE_IDX_W-1:0] mod_byte(input logic [MOD_IDX_W-1:0] m);
    return m[MOD_IDX_W-1:BIT_SEL_W];
  endfunction

  // Bit inside that byte.
  function automatic logic [BIT_SEL_W-1:0] mod_bit(input logic [MOD_IDX_W-1:0] m);
    return m[BIT_SEL_W-1:0];
  endfunction

endpackage

// File: rtl/barcode_region_tracker.sv
// barcode_region_tracker: S1 of the barcode pipe. Detects the start of the
// bar region on a qualifying line and walks pixel/module counters across it.
// Ports:
//   clk, rst        pixel clock, async active-high reset
//   de, x, y        video valid and raster position from the timing stage
//   in_bar          current pixel lies inside the bar region
//   mod_idx         module index of the current pixel
module barcode_region_tracker
  import barcode_render_pkg::*;
#(
  parameter int BAR_X0  = 40,
  parameter int BAR_Y0  = 96,
  parameter int BAR_H   = 80,
  parameter int MOD_W   = 4,
  parameter int NUM_MOD = 95
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 de,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  output logic                 in_bar,
  output logic [MOD_IDX_W-1:0] mod_idx
);

  logic [PIX_CNT_W-1:0] pix_cnt;
  logic                 start;
  logic                 last_pix;
  logic                 last_mod;

  assign start    = de && (int'(x) == BAR_X0) &&
                    (int'(y) >= BAR_Y0) && (int'(y) < BAR_Y0 + BAR_H);
  assign last_pix = (pix_cnt == PIX_CNT_W'(MOD_W - 1));
  assign last_mod = (mod_idx == MOD_IDX_W'(NUM_MOD - 1));

  // Region counters; losing de kills the line so a truncated line never carries over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_bar  <= 1'b0;
      pix_cnt <= '0;
      mod_idx <= '0;
    end else if (!de) begin
      in_bar  <= 1'b0;
      pix_cnt <= '0;
      mod_idx <= '0;
    end else if (start) begin
      in_bar  <= 1'b1;
      pix_cnt <= '0;
      mod_idx <= '0;
    end else if (in_bar) begin
      if (last_pix) begin
        pix_cnt <= '0;
        if (last_mod) begin
          in_bar  <= 1'b0;
          mod_idx <= '0;
        end else begin
          mod_idx <= mod_idx + MOD_IDX_W'(1);
        end
      end else begin
        pix_cnt <= pix_cnt + PIX_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/barcode_render.sv
// barcode_render: pixel stage drawing a 1-D barcode from a double-banked
// pattern ROM inside a fixed rectangle, background elsewhere. Fixed 3-clock
// latency from in_* to out_*; the displayed bank swaps only at vsync start.
// Optional feature macro: BARCODE_BORDER_EN (red 2-pixel frame round the bar).
// Ports:
//   rgb_clk, rgb_rst          pixel clock, async active-high reset
//   in_hs/in_vs/in_de         sync and valid from the timing stage
//   in_x, in_y                raster position
//   bank_req                  bank the loader wants displayed (level)
//   rom_addr, rom_data        {bank, byte} address; data 1 clock later
//   out_hs/out_vs/out_de      syncs delayed by 3 clocks
//   out_rgb                   pixel colour
//   bank_cur                  bank currently displayed
module barcode_render
  import barcode_render_pkg::*;
#(
  parameter int              BAR_X0    = 40,
  parameter int              BAR_Y0    = 96,
  parameter int              BAR_H     = 80,
  parameter int              MOD_W     = 4,
  parameter int              NUM_MOD   = 95,
  parameter logic [RGB_W-1:0] BAR_RGB   = RGB_BLACK,
  parameter logic [RGB_W-1:0] SPACE_RGB = RGB_WHITE,
  parameter logic [RGB_W-1:0] BG_RGB    = RGB_GREY,
  parameter logic            VS_POL    = 1'b0
) (
  input  logic              rgb_clk,
  input  logic              rgb_rst,
  input  logic              in_hs,
  input  logic              in_vs,
  input  logic              in_de,
  input  logic [9:0]        in_x,
  input  logic [9:0]        in_y,
  input  logic              bank_req,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              out_hs,
  output logic              out_vs,
  output logic              out_de,
  output logic [RGB_W-1:0]  out_rgb,
  output logic              bank_cur
);

  sync_t                 sync_s1, sync_s2, sync_s3;
  logic                  bar_s1, bar_s2;
  logic [MOD_IDX_W-1:0]  mod_idx_s1;
  logic [BIT_SEL_W-1:0]  sel_s2;
  logic                  vs_start;
  logic [RGB_W-1:0]      rgb_next;

  barcode_region_tracker #(
    .BAR_X0 (BAR_X0),
    .BAR_Y0 (BAR_Y0),
    .BAR_H  (BAR_H),
    .MOD_W  (MOD_W),
    .NUM_MOD(NUM_MOD)
  ) u_tracker (
    .clk    (rgb_clk),
    .rst    (rgb_rst),
    .de     (in_de),
    .x      (in_x),
    .y      (in_y),
    .in_bar (bar_s1),
    .mod_idx(mod_idx_s1)
  );

  // ROM address from S1 so the word lands alongside S2.
  assign rom_addr = {bank_cur, mod_byte(mod_idx_s1)};

  // sync_s1.vs is last cycle's in_vs, giving the leading edge of the pulse.
  assign vs_start = (in_vs == VS_POL) && (sync_s1.vs != VS_POL);

  // Sync delay line matched to the pixel pipe, plus the vsync-gated bank swap.
  always_ff @(posedge rgb_clk or posedge rgb_rst) begin
    if (rgb_rst) begin
      sync_s1  <= '0;
      sync_s2  <= '0;
      sync_s3  <= '0;
      bank_cur <= 1'b0;
    end else begin
      sync_s1 <= '{hs: in_hs, vs: in_vs, de: in_de};
      sync_s2 <= sync_s1;
      sync_s3 <= sync_s2;
      if (vs_start) bank_cur <= bank_req;
    end
  end

`ifdef BARCODE_BORDER_EN
  localparam int BAR_X1 = BAR_X0 + NUM_MOD * MOD_W;
  localparam int BAR_Y1 = BAR_Y0 + BAR_H;

  logic border_s1, border_s2;
  logic in_outer, in_inner;

  assign in_outer = (int'(in_x) >= BAR_X0 - 2) && (int'(in_x) <= BAR_X1 + 1) &&
                    (int'(in_y) >= BAR_Y0 - 2) && (int'(in_y) <= BAR_Y1 + 1);
  assign in_inner = (int'(in_x) >= BAR_X0) && (int'(in_x) < BAR_X1) &&
                    (int'(in_y) >= BAR_Y0) && (int'(in_y) < BAR_Y1);

  // Frame ring only, so the inner rectangle stays owned by the tracker.
  always_ff @(posedge rgb_clk or posedge rgb_rst) begin
    if (rgb_rst) begin
      border_s1 <= 1'b0;
      border_s2 <= 1'b0;
    end else begin
      border_s1 <= in_de && in_outer && !in_inner;
      border_s2 <= border_s1;
    end
  end
`endif

  // S2: region flag and bit select meet the ROM word.
  always_ff @(posedge rgb_clk or posedge rgb_rst) begin
    if (rgb_rst) begin
      bar_s2 <= 1'b0;
      sel_s2 <= '0;
    end else begin
      bar_s2 <= bar_s1;
      sel_s2 <= mod_bit(mod_idx_s1);
    end
  end

  // Colour select: bar over border over background/blank.
  always_comb begin
    rgb_next = sync_s2.de ? BG_RGB : RGB_OFF;
`ifdef BARCODE_BORDER_EN
    if (border_s2) rgb_next = RGB_BORDER;
`endif
    if (bar_s2) rgb_next = rom_data[sel_s2] ? BAR_RGB : SPACE_RGB;
  end

  // S3: registered pixel.
  always_ff @(posedge rgb_clk or posedge rgb_rst) begin
    if (rgb_rst) out_rgb <= '0;
    else         out_rgb <= rgb_next;
  end

  assign out_hs = sync_s3.hs;
  assign out_vs = sync_s3.vs;
  assign out_de = sync_s3.de;

endmodule

// File: tb/tb_barcode_render.sv
// tb_barcode_render: directed self-checking bench for barcode_render with
// default parameters and a behavioural synchronous pattern ROM.
module tb_barcode_render;

  logic        rgb_clk = 1'b0;
  logic        rgb_rst = 1'b1;
  logic        in_hs = 1'b0, in_vs = 1'b1, in_de = 1'b0;
  logic [9:0]  in_x = '0, in_y = '0;
  logic        bank_req = 1'b0;
  logic [4:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        out_hs, out_vs, out_de;
  logic [23:0] out_rgb;
  logic        bank_cur;

  barcode_render dut (
    .rgb_clk (rgb_clk),
    .rgb_rst (rgb_rst),
    .in_hs   (in_hs),
    .in_vs   (in_vs),
    .in_de   (in_de),
    .in_x    (in_x),
    .in_y    (in_y),
    .bank_req(bank_req),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .out_hs  (out_hs),
    .out_vs  (out_vs),
    .out_de  (out_de),
    .out_rgb (out_rgb),
    .bank_cur(bank_cur)
  );

  always #5 rgb_clk = ~rgb_clk;

  logic [7:0] rom [32];
  always @(posedge rgb_clk) rom_data <= rom[rom_addr];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] line_rgb [480];
  logic [3:0]  d_hs = '0, d_vs = '0, d_de = '0;
  int          d_x [4];
  logic        ra4_or, ra4_and;
  int          flips = 0;
  logic        bc_prev = 1'b0;

  always @(negedge rgb_clk) begin
    if (bank_cur !== bc_prev) flips++;
    bc_prev = bank_cur;
  end

  // Geometric reference picture, independent of the pipeline counters.
  function automatic logic [23:0] exp_rgb(input int x, input int y, input int bank);
    int m;
    logic [7:0] b;
    if (x >= 40 && x < 420 && y >= 96 && y < 176) begin
      m = (x - 40) / 4;
      b = rom[5'(bank * 16 + m / 8)];
      return b[3'(m % 8)] ? 24'h000000 : 24'hFFFFFF;
    end
`ifdef BARCODE_BORDER_EN
    if (x >= 38 && x <= 421 && y >= 94 && y <= 177) return 24'hFF0000;
`endif
    return 24'h404040;
  endfunction

  // One pixel clock: capture the output for the pixel driven 3 ticks ago, then drive.
  task automatic tick(input logic hs, input logic vs, input logic de, input int x, input int y);
    @(negedge rgb_clk);
    if (d_de[2] === 1'b1 && d_x[2] >= 0 && d_x[2] < 480) line_rgb[d_x[2]] = out_rgb;
    ra4_or  = ra4_or | rom_addr[4];
    ra4_and = ra4_and & rom_addr[4];
    d_hs = {d_hs[2:0], hs};
    d_vs = {d_vs[2:0], vs};
    d_de = {d_de[2:0], de};
    d_x[3] = d_x[2]; d_x[2] = d_x[1]; d_x[1] = d_x[0]; d_x[0] = x;
    in_hs = hs; in_vs = vs; in_de = de;
    in_x = 10'(x); in_y = 10'(y);
  endtask

  task automatic drive_line(input int y);
    for (int i = 0; i < 480; i++) line_rgb[i] = 'x;
    for (int x = 0; x < 480; x++) tick(1'b0, 1'b1, 1'b1, x, y);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 0, y);
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_reset();
    rgb_rst = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 0, 0);
    rgb_rst = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 0, 0);
    // reset hits line 100 after the bar has started
    for (int x = 0; x <= 120; x++) tick(1'b0, 1'b1, 1'b1, x, 100);
    rgb_rst = 1'b1;
    for (int x = 121; x <= 200; x++) tick(1'b1, 1'b1, 1'b1, x, 100);
    n_cmp++; if (out_rgb !== 24'h0) begin n_bad++; $display("FAIL rst_rgb got %h want 000000", out_rgb); end
    n_cmp++; if ({out_hs, out_vs, out_de} !== 3'b000) begin n_bad++; $display("FAIL rst_sync got %b want 000", {out_hs, out_vs, out_de}); end
    n_cmp++; if (rom_addr !== 5'd0) begin n_bad++; $display("FAIL rst_rom_addr got %0d want 0", rom_addr); end
    n_cmp++; if (bank_cur !== 1'b0) begin n_bad++; $display("FAIL rst_bank got %b want 0", bank_cur); end
    rgb_rst = 1'b0;
    for (int x = 201; x < 480; x++) tick(1'b0, 1'b1, 1'b1, x, 100);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 0, 100);
    n_cmp++; if (line_rgb[300] !== 24'h404040) begin n_bad++; $display("FAIL rst_trunc_line got %h want 404040", line_rgb[300]); end
    n_cmp++; if (line_rgb[419] !== 24'h404040) begin n_bad++; $display("FAIL rst_trunc_end got %h want 404040", line_rgb[419]); end
    drive_line(101);
    n_cmp++; if (line_rgb[40] !== 24'h000000) begin n_bad++; $display("FAIL rst_next_line got %h want 000000", line_rgb[40]); end
  endtask

  task automatic test_module_mapping();
    logic [23:0] want [13];
    want = '{24'h404040, 24'h000000, 24'h000000, 24'h000000, 24'h000000,
             24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
             24'h000000, 24'h000000, 24'h000000, 24'h000000};
    drive_line(96);
    for (int i = 0; i < 13; i++) begin
      n_cmp++;
      if (line_rgb[39 + i] !== want[i]) begin
        n_bad++; $display("FAIL map_x%0d got %h want %h", 39 + i, line_rgb[39 + i], want[i]);
      end
    end
    // byte 1 = 8'h2A: module 8 space, module 9 bar
    n_cmp++; if (line_rgb[72] !== 24'hFFFFFF) begin n_bad++; $display("FAIL map_mod8 got %h want FFFFFF", line_rgb[72]); end
    n_cmp++; if (line_rgb[76] !== 24'h000000) begin n_bad++; $display("FAIL map_mod9 got %h want 000000", line_rgb[76]); end
    for (int x = 0; x < 480; x++) begin
      n_cmp++;
      if (line_rgb[x] !== exp_rgb(x, 96, 0)) begin
        n_bad++; $display("FAIL map_line x=%0d got %h want %h", x, line_rgb[x], exp_rgb(x, 96, 0));
      end
    end
  endtask

  task automatic test_region_end();
    drive_line(175);
    // module 94 = byte 11 (8'h9C) bit 6 = 0
    n_cmp++; if (line_rgb[419] !== 24'hFFFFFF) begin n_bad++; $display("FAIL end_x419 got %h want FFFFFF", line_rgb[419]); end
    n_cmp++; if (line_rgb[420] !== 24'h404040) begin n_bad++; $display("FAIL end_x420 got %h want 404040", line_rgb[420]); end
    for (int x = 0; x < 480; x++) begin
      n_cmp++;
      if (line_rgb[x] !== exp_rgb(x, 175, 0)) begin
        n_bad++; $display("FAIL end_line x=%0d got %h want %h", x, line_rgb[x], exp_rgb(x, 175, 0));
      end
    end
    drive_line(176);
    n_cmp++; if (line_rgb[40] !== 24'h404040) begin n_bad++; $display("FAIL end_y176 got %h want 404040", line_rgb[40]); end
    n_cmp++; if (line_rgb[200] !== 24'h404040) begin n_bad++; $display("FAIL end_y176_mid got %h want 404040", line_rgb[200]); end
    drive_line(95);
    n_cmp++; if (line_rgb[40] !== exp_rgb(40, 95, 0)) begin n_bad++; $display("FAIL end_y95 got %h want %h", line_rgb[40], exp_rgb(40, 95, 0)); end
  endtask

  task automatic test_bank_swap();
    bank_req = 1'b0;
    vsync_pulse();
    flips = 0;
    drive_line(120);
    bank_req = 1'b1;
    ra4_or = 1'b0;
    drive_line(150);
    n_cmp++; if (ra4_or !== 1'b0) begin n_bad++; $display("FAIL swap_addr_early got %b want 0", ra4_or); end
    n_cmp++; if (bank_cur !== 1'b0) begin n_bad++; $display("FAIL swap_bank_early got %b want 0", bank_cur); end
    drive_line(151);
    n_cmp++; if (line_rgb[419] !== 24'hFFFFFF) begin n_bad++; $display("FAIL swap_old_pattern got %h want FFFFFF", line_rgb[419]); end
    tick(1'b0, 1'b0, 1'b0, 0, 0);
    n_cmp++; if (bank_cur !== 1'b0) begin n_bad++; $display("FAIL swap_before_edge got %b want 0", bank_cur); end
    tick(1'b0, 1'b0, 1'b0, 0, 0);
    n_cmp++; if (bank_cur !== 1'b1) begin n_bad++; $display("FAIL swap_after_edge got %b want 1", bank_cur); end
    vsync_pulse();
    ra4_and = 1'b1;
    drive_line(96);
    n_cmp++; if (ra4_and !== 1'b1) begin n_bad++; $display("FAIL swap_addr_new got %b want 1", ra4_and); end
    n_cmp++; if (line_rgb[40] !== 24'hFFFFFF) begin n_bad++; $display("FAIL swap_new_x40 got %h want FFFFFF", line_rgb[40]); end
    n_cmp++; if (line_rgb[419] !== 24'h000000) begin n_bad++; $display("FAIL swap_new_x419 got %h want 000000", line_rgb[419]); end
    for (int x = 0; x < 480; x++) begin
      n_cmp++;
      if (line_rgb[x] !== exp_rgb(x, 96, 1)) begin
        n_bad++; $display("FAIL swap_line x=%0d got %h want %h", x, line_rgb[x], exp_rgb(x, 96, 1));
      end
    end
    n_cmp++; if (flips !== 1) begin n_bad++; $display("FAIL swap_flip_count got %0d want 1", flips); end
    // several requests in one frame: only the last one counts
    bank_req = 1'b0; tick(1'b0, 1'b1, 1'b0, 0, 0);
    bank_req = 1'b1; tick(1'b0, 1'b1, 1'b0, 0, 0);
    bank_req = 1'b0; tick(1'b0, 1'b1, 1'b0, 0, 0);
    n_cmp++; if (bank_cur !== 1'b1) begin n_bad++; $display("FAIL swap_hold got %b want 1", bank_cur); end
    vsync_pulse();
    n_cmp++; if (bank_cur !== 1'b0) begin n_bad++; $display("FAIL swap_last_req got %b want 0", bank_cur); end
  endtask

  task automatic test_border();
    drive_line(94);
`ifdef BARCODE_BORDER_EN
    n_cmp++; if (line_rgb[38] !== 24'hFF0000) begin n_bad++; $display("FAIL border_38_94 got %h want FF0000", line_rgb[38]); end
`else
    n_cmp++; if (line_rgb[38] !== 24'h404040) begin n_bad++; $display("FAIL border_38_94 got %h want 404040", line_rgb[38]); end
`endif
    n_cmp++; if (line_rgb[37] !== 24'h404040) begin n_bad++; $display("FAIL border_37_94 got %h want 404040", line_rgb[37]); end
    drive_line(177);
`ifdef BARCODE_BORDER_EN
    n_cmp++; if (line_rgb[421] !== 24'hFF0000) begin n_bad++; $display("FAIL border_421_177 got %h want FF0000", line_rgb[421]); end
`else
    n_cmp++; if (line_rgb[421] !== 24'h404040) begin n_bad++; $display("FAIL border_421_177 got %h want 404040", line_rgb[421]); end
`endif
    n_cmp++; if (line_rgb[422] !== 24'h404040) begin n_bad++; $display("FAIL border_422_177 got %h want 404040", line_rgb[422]); end
  endtask

  task automatic test_sync_alignment();
    logic hs, vs, de;
    for (int i = 0; i < 400; i++) begin
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      de = 1'($urandom_range(0, 1));
      tick(hs, vs, de, int'($urandom_range(0, 479)), int'($urandom_range(0, 271)));
      n_cmp++;
      if ({out_hs, out_vs, out_de} !== {d_hs[3], d_vs[3], d_de[3]}) begin
        n_bad++;
        $display("FAIL sync_align cyc=%0d got %b want %b", i, {out_hs, out_vs, out_de}, {d_hs[3], d_vs[3], d_de[3]});
      end
      if (out_de === 1'b0) begin
        n_cmp++;
        if (out_rgb !== 24'h0) begin n_bad++; $display("FAIL sync_blank_rgb cyc=%0d got %h want 000000", i, out_rgb); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      rom[i]      = 8'(i * 37 + 5);
      rom[16 + i] = ~8'(i * 37 + 5);
    end
    for (int i = 0; i < 4; i++) d_x[i] = -1;
    ra4_or = 1'b0;
    ra4_and = 1'b1;
    test_reset();
    test_module_mapping();
    test_region_end();
    test_bank_swap();
    test_border();
    test_sync_alignment();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
